// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, memory depth default and pipeline register layouts
package mem_stage_pkg;
   localparam int WORD_W = 32;
   localparam int REG_ADDR_W = 5;
   localparam int DMEM_WORDS_DEFAULT = 256;
   typedef struct packed {
      logic                  branch;
      logic                  jump;
      logic                  mem_read;
      logic                  mem_write;
      logic                  reg_write;
      logic                  mem_to_reg;
      logic                  zero;
      logic [WORD_W-1:0]     add_out;
      logic [WORD_W-1:0]     alu_out;
      logic [WORD_W-1:0]     wdata;
      logic [REG_ADDR_W-1:0] write_reg;
   } ex_mem_t;
   typedef struct packed {
      logic                  reg_write;
      logic                  mem_to_reg;
      logic [WORD_W-1:0]     read_data;
      logic [WORD_W-1:0]     alu_result;
      logic [REG_ADDR_W-1:0] write_reg;
   } mem_wb_t;
endpackage

// File: rtl/mem_stage_data_memory.sv
// data_memory: word-addressed RAM, synchronous write, asynchronous read, optional clear on reset
module data_memory
   import mem_stage_pkg::*;
#(
   parameter int WORDS     = DMEM_WORDS_DEFAULT,
   parameter bit INIT_ZERO = 1
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_we,
   input  logic [$clog2(WORDS)-1:0] i_addr,
   input  logic [WORD_W-1:0]        i_wdata,
   output logic [WORD_W-1:0]        o_rdata
);
   logic [WORD_W-1:0] r_mem [WORDS];
   generate
      if (INIT_ZERO) begin : g_clr
         always_ff @(posedge i_clk or posedge i_rst)
            if (i_rst)
               for (int i = 0; i < WORDS; i++) r_mem[i] <= '0;
            else if (i_we)
               r_mem[i_addr] <= i_wdata;
      end else begin : g_keep
         // contents survive reset, but a write coinciding with reset is still dropped
         always_ff @(posedge i_clk)
            if (i_we && !i_rst) r_mem[i_addr] <= i_wdata;
      end
   endgenerate
   assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/mem_stage.sv
// mem_stage: EX/MEM and MEM/WB pipeline registers, branch resolution and data memory access
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DMEM_WORDS = DMEM_WORDS_DEFAULT,
   parameter bit INIT_ZERO  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  branch,
   input  logic                  jump,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic                  RegWrite,
   input  logic                  MemtoReg,
   input  logic [WORD_W-1:0]     add_out,
   input  logic [WORD_W-1:0]     alu_out,
   input  logic                  aluzero,
   input  logic [WORD_W-1:0]     readdata2,
   input  logic [REG_ADDR_W-1:0] write_reg,
   output logic                  pc_src,
   output logic [WORD_W-1:0]     branch_target,
   output logic                  RegWrite_wb,
   output logic                  MemtoReg_wb,
   output logic [WORD_W-1:0]     read_data_wb,
   output logic [WORD_W-1:0]     alu_result_wb,
   output logic [REG_ADDR_W-1:0] write_reg_wb,
   output logic                  misaligned
);
   localparam int AW = $clog2(DMEM_WORDS);
   ex_mem_t           r_ex;
   mem_wb_t           r_wb;
   logic              r_mis;
   logic              w_mis;
   logic              w_we;
   logic [WORD_W-1:0] w_rdata;
   // flush zeroes the control bits that could change architectural state, and beats stall
   always_ff @(posedge clk or posedge rst)
      if (rst)
         r_ex <= '0;
      else if (flush || !stall)
         r_ex <= '{branch:     branch & ~flush,
                   jump:       jump & ~flush,
                   mem_read:   MemRead & ~flush,
                   mem_write:  MemWrite & ~flush,
                   reg_write:  RegWrite & ~flush,
                   mem_to_reg: MemtoReg,
                   zero:       aluzero,
                   add_out:    add_out,
                   alu_out:    alu_out,
                   wdata:      readdata2,
                   write_reg:  write_reg};
   assign w_mis = (r_ex.alu_out[1:0] != 2'b00) && (r_ex.mem_read || r_ex.mem_write);
   assign w_we  = r_ex.mem_write && !w_mis && !stall;
   data_memory #(.WORDS(DMEM_WORDS), .INIT_ZERO(INIT_ZERO)) u_dmem (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_we    (w_we),
      .i_addr  (r_ex.alu_out[AW+1:2]),
      .i_wdata (r_ex.wdata),
      .o_rdata (w_rdata)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_wb  <= '0;
         r_mis <= 1'b0;
      end else begin
         r_wb  <= '{reg_write:  r_ex.reg_write & ~w_mis & ~stall,
                    mem_to_reg: r_ex.mem_to_reg,
                    read_data:  (r_ex.mem_read && !w_mis) ? w_rdata : '0,
                    alu_result: r_ex.alu_out,
                    write_reg:  r_ex.write_reg};
         r_mis <= r_mis | w_mis;
      end
   assign pc_src        = (r_ex.branch & r_ex.zero) | r_ex.jump;
   assign branch_target = r_ex.add_out;
   assign RegWrite_wb   = r_wb.reg_write;
   assign MemtoReg_wb   = r_wb.mem_to_reg;
   assign read_data_wb  = r_wb.read_data;
   assign alu_result_wb = r_wb.alu_result;
   assign write_reg_wb  = r_wb.write_reg;
   assign misaligned    = r_mis;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage
module tb_mem_stage;
   logic        clk = 0, rst = 0, stall = 0, flush = 0;
   logic        branch = 0, jump = 0, MemRead = 0, MemWrite = 0, RegWrite = 0, MemtoReg = 0, aluzero = 0;
   logic [31:0] add_out = 0, alu_out = 0, readdata2 = 0;
   logic [4:0]  write_reg = 0;
   logic        pc_src, RegWrite_wb, MemtoReg_wb, misaligned;
   logic [31:0] branch_target, read_data_wb, alu_result_wb;
   logic [4:0]  write_reg_wb;
   int          n_cmp = 0, n_err = 0;

   mem_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .branch(branch), .jump(jump), .MemRead(MemRead), .MemWrite(MemWrite),
      .RegWrite(RegWrite), .MemtoReg(MemtoReg), .add_out(add_out), .alu_out(alu_out),
      .aluzero(aluzero), .readdata2(readdata2), .write_reg(write_reg),
      .pc_src(pc_src), .branch_target(branch_target), .RegWrite_wb(RegWrite_wb),
      .MemtoReg_wb(MemtoReg_wb), .read_data_wb(read_data_wb), .alu_result_wb(alu_result_wb),
      .write_reg_wb(write_reg_wb), .misaligned(misaligned)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      stall = 0; flush = 0; branch = 0; jump = 0; MemRead = 0; MemWrite = 0;
      RegWrite = 0; MemtoReg = 0; aluzero = 0; add_out = 0; alu_out = 0;
      readdata2 = 0; write_reg = 0;
   endtask

   task automatic test_reset;
      logic [104:0] all_out;
      #1 rst = 1;
      jump = 1; RegWrite = 1; add_out = 32'h55; alu_out = 32'h77;
      #2;
      all_out = {pc_src, branch_target, RegWrite_wb, MemtoReg_wb, read_data_wb, alu_result_wb, write_reg_wb, misaligned};
      if (all_out !== 105'b0) begin n_err++; $display("FAIL rst_outputs got %h want 0", all_out); end
      n_cmp++;
      tick;
      tick;
      all_out = {pc_src, branch_target, RegWrite_wb, MemtoReg_wb, read_data_wb, alu_result_wb, write_reg_wb, misaligned};
      if (all_out !== 105'b0) begin n_err++; $display("FAIL rst_held got %h want 0", all_out); end
      n_cmp++;
      #3 rst = 0;
      tick;
      if ({pc_src, branch_target} !== {1'b1, 32'h55}) begin
         n_err++; $display("FAIL rst_first_capture got %b/%h want 1/00000055", pc_src, branch_target);
      end
      n_cmp++;
      idle;
      tick;
   endtask

   task automatic test_branch;
      idle; branch = 1; aluzero = 1; add_out = 32'h40;
      tick;
      if ({pc_src, branch_target} !== {1'b1, 32'h40}) begin
         n_err++; $display("FAIL br_taken got %b/%h want 1/00000040", pc_src, branch_target);
      end
      n_cmp++;
      aluzero = 0;
      tick;
      if (pc_src !== 1'b0) begin n_err++; $display("FAIL br_not_taken got %b want 0", pc_src); end
      n_cmp++;
      idle; jump = 1; add_out = 32'h88;
      tick;
      if ({pc_src, branch_target} !== {1'b1, 32'h88}) begin
         n_err++; $display("FAIL jump got %b/%h want 1/00000088", pc_src, branch_target);
      end
      n_cmp++;
      idle;
      tick;
   endtask

   task automatic test_store_load;
      idle; MemWrite = 1; alu_out = 32'h10; readdata2 = 32'hDEADBEEF;
      tick;
      idle; MemRead = 1; MemtoReg = 1; RegWrite = 1; alu_out = 32'h10; write_reg = 5'd5;
      tick;
      if ({RegWrite_wb, read_data_wb} !== {1'b0, 32'h0}) begin
         n_err++; $display("FAIL st_wb_store got %b/%h want 0/00000000", RegWrite_wb, read_data_wb);
      end
      n_cmp++;
      idle;
      tick;
      if ({RegWrite_wb, MemtoReg_wb, read_data_wb, alu_result_wb, write_reg_wb} !== {1'b1, 1'b1, 32'hDEADBEEF, 32'h10, 5'd5}) begin
         n_err++; $display("FAIL st_ld_forward got %b %b %h %h %0d want 1 1 deadbeef 00000010 5",
                           RegWrite_wb, MemtoReg_wb, read_data_wb, alu_result_wb, write_reg_wb);
      end
      n_cmp++;
      if (misaligned !== 1'b0) begin n_err++; $display("FAIL st_ld_misaligned got %b want 0", misaligned); end
      n_cmp++;
   endtask

   task automatic test_alu_pass;
      idle; RegWrite = 1; alu_out = 32'h12345678; write_reg = 5'd0; readdata2 = 32'hFFFF0000;
      tick;
      idle;
      if (RegWrite_wb !== 1'b0) begin n_err++; $display("FAIL alu_latency got %b want 0", RegWrite_wb); end
      n_cmp++;
      tick;
      if ({RegWrite_wb, MemtoReg_wb, read_data_wb, alu_result_wb, write_reg_wb} !== {1'b1, 1'b0, 32'h0, 32'h12345678, 5'd0}) begin
         n_err++; $display("FAIL alu_pass got %b %b %h %h %0d want 1 0 00000000 12345678 0",
                           RegWrite_wb, MemtoReg_wb, read_data_wb, alu_result_wb, write_reg_wb);
      end
      n_cmp++;
   endtask

   task automatic test_stall;
      idle; MemWrite = 1; RegWrite = 1; write_reg = 5'd3; alu_out = 32'h20;
      readdata2 = 32'hCAFEF00D; add_out = 32'h100;
      tick;
      stall = 1; MemWrite = 0; write_reg = 5'd7; alu_out = 32'h24; add_out = 32'h200; readdata2 = 32'h0;
      tick;
      if (dut.u_dmem.r_mem[8] !== 32'h0) begin
         n_err++; $display("FAIL stall_no_write got %h want 00000000", dut.u_dmem.r_mem[8]);
      end
      n_cmp++;
      if ({RegWrite_wb, branch_target} !== {1'b0, 32'h100}) begin
         n_err++; $display("FAIL stall_hold got %b/%h want 0/00000100", RegWrite_wb, branch_target);
      end
      n_cmp++;
      idle;
      tick;
      if (dut.u_dmem.r_mem[8] !== 32'hCAFEF00D) begin
         n_err++; $display("FAIL stall_release_write got %h want cafef00d", dut.u_dmem.r_mem[8]);
      end
      n_cmp++;
      if ({RegWrite_wb, write_reg_wb} !== {1'b1, 5'd3}) begin
         n_err++; $display("FAIL stall_release_wb got %b/%0d want 1/3", RegWrite_wb, write_reg_wb);
      end
      n_cmp++;
      MemRead = 1; RegWrite = 1; alu_out = 32'h20;
      tick;
      idle;
      tick;
      if (read_data_wb !== 32'hCAFEF00D) begin
         n_err++; $display("FAIL stall_load got %h want cafef00d", read_data_wb);
      end
      n_cmp++;
   endtask

   task automatic test_flush;
      idle; jump = 1; RegWrite = 1;
      tick;
      if (pc_src !== 1'b1) begin n_err++; $display("FAIL flush_pre got %b want 1", pc_src); end
      n_cmp++;
      flush = 1; stall = 1;
      tick;
      if (pc_src !== 1'b0) begin n_err++; $display("FAIL flush_pc_src got %b want 0", pc_src); end
      n_cmp++;
      idle;
      tick;
      if (RegWrite_wb !== 1'b0) begin n_err++; $display("FAIL flush_regwrite got %b want 0", RegWrite_wb); end
      n_cmp++;
   endtask

   task automatic test_misaligned;
      idle; MemWrite = 1; alu_out = 32'h13; readdata2 = 32'h11111111;
      tick;
      idle;
      tick;
      if (dut.u_dmem.r_mem[4] !== 32'hDEADBEEF) begin
         n_err++; $display("FAIL mis_store_mem got %h want deadbeef", dut.u_dmem.r_mem[4]);
      end
      n_cmp++;
      if (misaligned !== 1'b1) begin n_err++; $display("FAIL mis_flag got %b want 1", misaligned); end
      n_cmp++;
      MemRead = 1; RegWrite = 1; alu_out = 32'h11;
      tick;
      idle;
      tick;
      if ({RegWrite_wb, read_data_wb} !== {1'b0, 32'h0}) begin
         n_err++; $display("FAIL mis_load got %b/%h want 0/00000000", RegWrite_wb, read_data_wb);
      end
      n_cmp++;
      repeat (3) tick;
      if (misaligned !== 1'b1) begin n_err++; $display("FAIL mis_sticky got %b want 1", misaligned); end
      n_cmp++;
   endtask

   task automatic test_reset_mid_store;
      logic [104:0] all_out;
      idle; MemWrite = 1; RegWrite = 1; jump = 1; alu_out = 32'h30;
      readdata2 = 32'hA5A5A5A5; add_out = 32'h80;
      tick;
      if (pc_src !== 1'b1) begin n_err++; $display("FAIL rms_pre got %b want 1", pc_src); end
      n_cmp++;
      #2 rst = 1;
      #1;
      all_out = {pc_src, branch_target, RegWrite_wb, MemtoReg_wb, read_data_wb, alu_result_wb, write_reg_wb, misaligned};
      if (all_out !== 105'b0) begin n_err++; $display("FAIL rms_outputs got %h want 0", all_out); end
      n_cmp++;
      idle;
      @(posedge clk);
      #3;
      if ({dut.u_dmem.r_mem[12], dut.u_dmem.r_mem[4]} !== 64'h0) begin
         n_err++; $display("FAIL rms_mem got %h/%h want 0/0", dut.u_dmem.r_mem[12], dut.u_dmem.r_mem[4]);
      end
      n_cmp++;
      rst = 0;
      MemRead = 1; RegWrite = 1; alu_out = 32'h30;
      tick;
      idle;
      tick;
      if ({RegWrite_wb, read_data_wb, misaligned} !== {1'b1, 32'h0, 1'b0}) begin
         n_err++; $display("FAIL rms_load got %b/%h/%b want 1/00000000/0", RegWrite_wb, read_data_wb, misaligned);
      end
      n_cmp++;
   endtask

   initial begin
      test_reset;
      test_branch;
      test_store_load;
      test_alu_pass;
      test_stall;
      test_flush;
      test_misaligned;
      test_reset_mid_store;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: DMEM_WORDS, default 256, data memory depth in 32-bit words (power of two).
REQ-002 Parameter: INIT_ZERO, default 1, clear data memory contents on reset when 1.
REQ-003 Ports (clock and reset first): clk input 1, the only clock; rst input 1, asynchronous active-high reset.
REQ-004 stall input 1, hold EX/MEM contents, insert bubble into MEM/WB; flush input 1, turn EX/MEM into bubble on next edge.
REQ-005 branch, jump, MemRead, MemWrite, RegWrite, MemtoReg inputs 1 each, control bits from execute stage.
REQ-006 add_out input 32, branch target; alu_out input 32, ALU result / byte address; aluzero input 1, ALU zero flag.
REQ-007 readdata2 input 32, store data; write_reg input 5, destination register from RegDst mux.
REQ-008 pc_src output 1, take branch/jump; branch_target output 32, registered add_out.
REQ-009 RegWrite_wb, MemtoReg_wb output 1 each; read_data_wb output 32; alu_result_wb output 32; write_reg_wb output 5.
REQ-010 misaligned output 1, sticky access-alignment error.

Function
REQ-011 EX/MEM register SHALL capture all execute inputs on every rising clk edge with stall=0 and flush=0.
REQ-012 flush=1 SHALL load EX/MEM with branch, jump, MemRead, MemWrite, RegWrite all 0 (bubble); flush overrides stall.
REQ-013 stall=1, flush=0 SHALL hold EX/MEM unchanged, suppress memory write, load MEM/WB with RegWrite_wb=0.
REQ-014 pc_src SHALL be combinational from EX/MEM: (branch_q AND zero_q) OR jump_q; branch_target = add_out_q.
REQ-015 Word index SHALL be alu_out_q[log2(DMEM_WORDS)+1:2]; upper address bits ignored (wrap-around).
REQ-016 Store: MemWrite_q=1, aligned, not stalled -> memory[index] <= readdata2_q at rising edge.
REQ-017 Load: read combinational from memory at index; MEM/WB captures read data on same edge.
REQ-018 Store at cycle N followed by load of same address at cycle N+1 SHALL return the stored value.
REQ-019 Latency: inputs captured at edge E appear on *_wb outputs after edge E+1 (2 cycles).
REQ-020 Misaligned (alu_out_q[1:0] != 0 with MemRead_q or MemWrite_q): write suppressed, read_data_wb = 0, RegWrite_wb forced 0, misaligned set and held until reset.
REQ-021 MEM/WB SHALL pass alu_out_q, write_reg_q, MemtoReg_q unmodified; read_data_wb = 0 when MemRead_q=0.
REQ-022 Write to write_reg 0 SHALL propagate normally; register file discards it.

Reset
REQ-023 rst asserted SHALL immediately clear EX/MEM and MEM/WB: all control outputs 0, all data outputs 0, pc_src 0, misaligned 0.
REQ-024 rst mid-store SHALL abort the write; memory cleared when INIT_ZERO=1, otherwise retained.
REQ-025 First capture occurs on first rising edge after rst deasserts.

Structure
REQ-026 Shared package SHALL hold WORD_W=32, REG_ADDR_W=5, DMEM_WORDS default, and the EX/MEM and MEM/WB field definitions.
REQ-027 Data memory SHALL be a sub-module data_memory (sync write, async read, parameterized depth).
REQ-028 pc_src logic and pipeline registers SHALL stay in mem_stage.

Verification
REQ-029 Store alu_out=0x10, readdata2=0xDEADBEEF; next cycle load 0x10, MemtoReg=1 -> read_data_wb=0xDEADBEEF, RegWrite_wb=1 two cycles after load issue.
REQ-030 branch=1, aluzero=1, add_out=0x40 -> pc_src=1, branch_target=0x40 one cycle later; aluzero=0 -> pc_src=0.
REQ-031 Store with alu_out=0x13 -> memory unchanged, misaligned=1 and stays 1 until rst.
REQ-032 stall=1 with pending store -> memory unchanged, EX/MEM held, RegWrite_wb=0; stall released -> store completes.
REQ-033 flush=1 and stall=1 same cycle with jump=1 input -> next cycle pc_src=0, RegWrite_wb=0 following edge.
REQ-034 rst asserted between edges during store -> all outputs 0 immediately, no write observed at address.
